// File: rtl/matrix_loader.sv
// matrix_loader: packs N_ELEM streamed elements into one memory word per matrix; write 1 cycle after last element.
// Stalls input (in_ready=0) outside FILL; optional burst checksum under LOADER_CHECKSUM_EN.
module matrix_loader #(
  parameter int N_ELEM = 25,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        num_mat,
  input  logic [ELEM_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [N_ELEM*ELEM_W-1:0] mem_data,
  output logic                     mem_wren,
  output logic                     busy,
  output logic                     done,
  output logic [ELEM_W-1:0]        checksum
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        r_remain;
  logic [N_ELEM*ELEM_W-1:0] r_buf;

  logic w_accept;
  logic w_last;
  logic w_start_acc;

  assign w_accept    = (r_state == S_FILL) && in_valid;
  assign w_last      = (r_idx == IDX_W'(N_ELEM - 1));
  assign w_start_acc = (r_state == S_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_buf    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_mat != '0) begin
              r_addr   <= start_addr;
              r_remain <= num_mat;
              r_idx    <= '0;
              r_state  <= S_FILL;
            end else begin
              r_state  <= S_DONE;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            // Buffer is never cleared between matrices; each slot is overwritten in turn.
            for (int k = 0; k < N_ELEM; k++) begin
              if (r_idx == IDX_W'(k)) r_buf[k*ELEM_W +: ELEM_W] <= in_data;
            end
            if (w_last) r_state <= S_WRITE;
            else        r_idx   <= r_idx + IDX_W'(1);
          end
        end
        S_WRITE: begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - ADDR_W'(1);
          r_idx    <= '0;
          r_state  <= (r_remain == ADDR_W'(1)) ? S_DONE : S_FILL;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == S_FILL);
  assign mem_wren = (r_state == S_WRITE);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign mem_addr = r_addr;
  assign mem_data = r_buf;

`ifdef LOADER_CHECKSUM_EN
  logic [ELEM_W-1:0] r_sum;

  always_ff @(posedge clock) begin
    if (reset)            r_sum <= '0;
    else if (w_start_acc) r_sum <= '0;
    else if (w_accept)    r_sum <= r_sum + in_data;
  end

  assign checksum = r_sum;
`else
  logic w_unused_start;
  assign w_unused_start = w_start_acc;
  assign checksum       = '0;
`endif

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter N_ELEM, default 25, elements per matrix (5x5).
REQ-002 SHALL have parameter ELEM_W, default 8, element width in bits.
REQ-003 SHALL have parameter ADDR_W, default 3, memory address width.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load burst.
REQ-007 SHALL have port start_addr  input  ADDR_W  first memory word to write.
REQ-008 SHALL have port num_mat  input  ADDR_W  matrices in the burst; 0 means none.
REQ-009 SHALL have port in_data  input  ELEM_W  incoming element, row-major order.
REQ-010 SHALL have port in_valid  input  1  in_data is valid.
REQ-011 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-012 SHALL have port mem_addr  output  ADDR_W  write address to matrix memory.
REQ-013 SHALL have port mem_data  output  N_ELEM*ELEM_W  flattened matrix write data.
REQ-014 SHALL have port mem_wren  output  1  memory write enable.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle burst-complete pulse.
REQ-017 SHALL have port checksum  output  ELEM_W  burst element sum (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-019 IDLE: start=1 with num_mat!=0 SHALL latch start_addr and num_mat, clear element index, go to FILL.
REQ-020 IDLE: start=1 with num_mat=0 SHALL go directly to DONE; no memory write.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 in_ready SHALL be 1 only in FILL; element accepted when in_valid and in_ready are both 1.
REQ-023 Accepted element k (0..N_ELEM-1) SHALL be stored at mem_data[ELEM_W*k +: ELEM_W].
REQ-024 Acceptance of element N_ELEM-1 SHALL move FSM to WRITE on the next edge.
REQ-025 WRITE SHALL last exactly one cycle with mem_wren=1, mem_addr=current address, mem_data=assembled matrix.
REQ-026 mem_wren SHALL be 0 in every state except WRITE.
REQ-027 Latency: mem_wren SHALL assert the cycle after the last element is accepted.
REQ-028 After WRITE, address SHALL increment modulo 2^ADDR_W (7 wraps to 0); remaining count SHALL decrement.
REQ-029 After WRITE, remaining=0 SHALL go to DONE, else to FILL with element index cleared.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-031 busy SHALL be 1 in FILL, WRITE and DONE, 0 in IDLE.
REQ-032 in_valid while in_ready=0 SHALL be ignored; no element consumed.
REQ-033 mem_data SHALL hold its value outside WRITE; stale elements are not cleared between matrices.

Reset
REQ-034 reset=1 SHALL force IDLE and clear index, address, count, assembly buffer and checksum.
REQ-035 During reset, in_ready, mem_wren, busy and done SHALL be 0; mem_addr=0; mem_data=0; checksum=0.
REQ-036 Reset during FILL or WRITE SHALL abort the burst; no write issued after the reset cycle.
REQ-037 Reset SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-038 Macro LOADER_CHECKSUM_EN defined: checksum SHALL be the modulo-2^ELEM_W sum of all elements accepted since the last accepted start, cleared on start, stable while done=1.
REQ-039 Macro LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no summing logic is built.

Verification
REQ-040 reset, start, start_addr=2, num_mat=1, 25 elements 1..25 back-to-back -> one mem_wren at addr 2, byte k=k+1, done one cycle later; checksum=0x45 with macro, else 0.
REQ-041 start_addr=7, num_mat=2, elements 0xAA then 0x55 -> writes at addr 7 then 0, all bytes 0xAA then 0x55; single done pulse.
REQ-042 in_valid toggled every other cycle during FILL -> only valid-and-ready cycles consumed; matrix identical to REQ-040 image.
REQ-043 start with num_mat=0 -> done the next cycle, mem_wren never asserts, busy high for one cycle.
REQ-044 reset asserted after 10 elements accepted -> no mem_wren; all outputs 0; new start loads cleanly.
REQ-045 start pulsed during FILL with start_addr=5 -> ignored; write goes to the originally latched address.
